vector_reduce_engine: RTL

Parametrised, streaming successor to the single-shot lane reducer in the data_ops datapath. It reduces a multi-beat vector of LANES elements per beat to one scalar: SUM, MAX, MIN, MEAN, ARGMAX or ARGMIN. It supports signed and unsigned operands, cross-beat accumulation terminated by in_last, saturation, and a registered two-stage pipeline with full valid/ready backpressure. It sits between the vector register/activation buffers and the scalar writeback path.

---
 rtl/vector_reduce_engine_pkg.sv | 22 ++
 rtl/vector_reduce_engine_reduce_lane_tree.sv | 59 +++++
 rtl/vector_reduce_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vector_reduce_engine_pkg.sv
// rtl/vector_reduce_engine_pkg.sv - mode codes, FSM state type and mode helpers for vector_reduce_engine
package vector_reduce_engine_pkg;

  localparam logic [2:0] RED_SUM    = 3'd0;
  localparam logic [2:0] RED_MAX    = 3'd1;
  localparam logic [2:0] RED_MIN    = 3'd2;
  localparam logic [2:0] RED_MEAN   = 3'd3;
  localparam logic [2:0] RED_ARGMAX = 3'd4;
  localparam logic [2:0] RED_ARGMIN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } vre_state_t;

  function automatic logic is_max_mode(input logic [2:0] m);
    return (m == RED_MAX) || (m == RED_ARGMAX);
  endfunction

endpackage

// File: rtl/vector_reduce_engine_reduce_lane_tree.sv
// rtl/vector_reduce_engine_reduce_lane_tree.sv - registered intra-beat sum and best-lane tree
module reduce_lane_tree #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  localparam int LANE_LOG2 = $clog2(LANES),
  localparam int SUM_W     = DATA_W + LANE_LOG2 + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES*DATA_W-1:0]     in_data,
  input  logic                        in_valid,
  input  logic                        signed_en,
  input  logic                        find_max,
  output logic                        out_valid,
  output logic signed [SUM_W-1:0]     out_sum,
  output logic signed [DATA_W:0]      out_best,
  output logic [LANE_LOG2-1:0]        out_lane
);

  localparam int NODES = 2*LANES - 1;

  // Heap layout: leaves at LANES-1.., node n has children 2n+1 (lower lanes) and 2n+2.
  logic signed [SUM_W-1:0]  sum_n  [NODES];
  logic signed [DATA_W:0]   best_n [NODES];
  logic [LANE_LOG2-1:0]     lane_n [NODES];
  logic                     right_wins;

  always_comb begin
    right_wins = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      best_n[LANES-1+l] = {signed_en & in_data[l*DATA_W + DATA_W-1], in_data[l*DATA_W +: DATA_W]};
      sum_n[LANES-1+l]  = {{LANE_LOG2{best_n[LANES-1+l][DATA_W]}}, best_n[LANES-1+l]};
      lane_n[LANES-1+l] = LANE_LOG2'(l);
    end
    for (int n = LANES-2; n >= 0; n--) begin
      sum_n[n]   = sum_n[2*n+1] + sum_n[2*n+2];
      right_wins = find_max ? (best_n[2*n+2] > best_n[2*n+1]) : (best_n[2*n+2] < best_n[2*n+1]);
      best_n[n]  = right_wins ? best_n[2*n+2] : best_n[2*n+1];
      lane_n[n]  = right_wins ? lane_n[2*n+2] : lane_n[2*n+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_best  <= '0;
      out_lane  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sum  <= sum_n[0];
        out_best <= best_n[0];
        out_lane <= lane_n[0];
      end
    end
  end

endmodule

// File: rtl/vector_reduce_engine.sv
// rtl/vector_reduce_engine.sv - streaming multi-beat vector to scalar reducer with backpressure
module vector_reduce_engine
  import vector_reduce_engine_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LANES     = 16,
  parameter int MAX_BEATS = 16,
  localparam int LANE_LOG2 = $clog2(LANES),
  localparam int BEAT_W    = $clog2(MAX_BEATS),
  localparam int ACC_W     = DATA_W + LANE_LOG2 + BEAT_W + 1,
  localparam int IDX_W     = $clog2(LANES*MAX_BEATS),
  localparam int SUM_W     = DATA_W + LANE_LOG2 + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [2:0]              mode,
  input  logic                    signed_en,
  input  logic [3:0]              mean_shift,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_sat,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - 1;
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((64'sd1 <<< DATA_W) - 1);

  vre_state_t              state;
  logic [2:0]              mode_q;
  logic                    signed_q;
  logic [3:0]              shift_q;
  logic [DATA_W-1:0]       lane0_q;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    s1_first, s1_last, s1_err;
  logic [BEAT_W-1:0]       s1_beat;
  logic                    s1_valid;
  logic signed [SUM_W-1:0] s1_sum;
  logic signed [DATA_W:0]  s1_best;
  logic [LANE_LOG2-1:0]    s1_lane;
  logic signed [ACC_W-1:0] acc_q, acc_nxt, s1_sum_ext, pre;
  logic signed [DATA_W:0]  best_q, best_nxt;
  logic [IDX_W-1:0]        idx_q, idx_nxt, s1_idx;
  logic                    better;
  logic [DATA_W-1:0]       clamp_data, res_data;
  logic                    clamp_sat, res_sat, res_err;
  logic [IDX_W-1:0]        res_idx;

  logic       accept, first_beat, cnt_full, beat_last, cur_signed;
  logic [2:0] cur_mode;

  assign in_ready   = (state == ST_IDLE) || (state == ST_ACCUM);
  assign busy       = (state != ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign first_beat = (state == ST_IDLE);
  assign cnt_full   = (beat_cnt == BEAT_W'(MAX_BEATS-1));
  assign beat_last  = in_last || cnt_full;
  // The first beat is reduced with the live controls; later beats use the latched copy.
  assign cur_mode   = first_beat ? mode : mode_q;
  assign cur_signed = first_beat ? signed_en : signed_q;

  reduce_lane_tree #(.DATA_W(DATA_W), .LANES(LANES)) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (accept),
    .signed_en (cur_signed),
    .find_max  (is_max_mode(cur_mode)),
    .out_valid (s1_valid),
    .out_sum   (s1_sum),
    .out_best  (s1_best),
    .out_lane  (s1_lane)
  );

  always_comb begin
    acc_nxt    = acc_q;
    best_nxt   = best_q;
    idx_nxt    = idx_q;
    better     = 1'b0;
    s1_sum_ext = {{(ACC_W-SUM_W){s1_sum[SUM_W-1]}}, s1_sum};
    s1_idx     = IDX_W'({s1_beat, s1_lane});
    if (s1_first) begin
      acc_nxt  = s1_sum_ext;
      best_nxt = s1_best;
      idx_nxt  = s1_idx;
    end else begin
      acc_nxt = acc_q + s1_sum_ext;
      // Strict compare so cross-beat ties keep the earlier index.
      better  = is_max_mode(mode_q) ? (s1_best > best_q) : (s1_best < best_q);
      if (better) begin
        best_nxt = s1_best;
        idx_nxt  = s1_idx;
      end
    end
    pre        = (mode_q == RED_MEAN) ? (acc_nxt >>> (LANE_LOG2 + 32'(shift_q))) : acc_nxt;
    clamp_data = pre[DATA_W-1:0];
    clamp_sat  = 1'b0;
    if (signed_q) begin
      if (pre > S_MAX) begin
        clamp_data = S_MAX[DATA_W-1:0];
        clamp_sat  = 1'b1;
      end else if (pre < S_MIN) begin
        clamp_data = S_MIN[DATA_W-1:0];
        clamp_sat  = 1'b1;
      end
    end else if (pre > U_MAX) begin
      clamp_data = U_MAX[DATA_W-1:0];
      clamp_sat  = 1'b1;
    end
    res_data = clamp_data;
    res_idx  = '0;
    res_sat  = 1'b0;
    res_err  = s1_err;
    case (mode_q)
      RED_SUM, RED_MEAN: res_sat = clamp_sat;
      RED_MAX, RED_MIN:  res_data = best_nxt[DATA_W-1:0];
      RED_ARGMAX, RED_ARGMIN: begin
        res_data = best_nxt[DATA_W-1:0];
        res_idx  = idx_nxt;
      end
      default: begin
        res_data = lane0_q;
        res_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= RED_SUM;
      signed_q  <= 1'b0;
      shift_q   <= '0;
      lane0_q   <= '0;
      beat_cnt  <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_err    <= 1'b0;
      s1_beat   <= '0;
      acc_q     <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_sat   <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (first_beat) begin
          mode_q   <= mode;
          signed_q <= signed_en;
          shift_q  <= mean_shift;
          lane0_q  <= in_data[DATA_W-1:0];
        end
        s1_first <= first_beat;
        s1_last  <= beat_last;
        s1_err   <= cnt_full && !in_last;
        s1_beat  <= beat_cnt;
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end
      if (s1_valid) begin
        acc_q  <= acc_nxt;
        best_q <= best_nxt;
        idx_q  <= idx_nxt;
      end
      unique case (state)
        ST_IDLE:  if (accept) state <= beat_last ? ST_DRAIN : ST_ACCUM;
        ST_ACCUM: if (accept && beat_last) state <= ST_DRAIN;
        ST_DRAIN: if (s1_valid && s1_last) begin
          state     <= ST_HOLD;
          out_valid <= 1'b1;
          out_data  <= res_data;
          out_idx   <= res_idx;
          out_sat   <= res_sat;
          out_err   <= res_err;
        end
        ST_HOLD: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
